// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants and dump FSM state encoding for the register-file dump reader.
package regfile_dump_reader_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;
    localparam int PAIR_W   = ADDR_W - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_SEND_A = 3'd2,
        ST_SEND_B = 3'd3,
        ST_DONE   = 3'd4
    } dump_state_e;

    // Even register of a pair when odd=0, odd register when odd=1.
    function automatic logic [ADDR_W-1:0] pair_addr(input logic [PAIR_W-1:0] p, input logic odd);
        return {p, odd};
    endfunction
endpackage

// File: rtl/regfile_dump_reader_if.sv
// Register-file read ports plus the (address, value) output stream of the dump reader.
interface regfile_dump_reader_if;
    import regfile_dump_reader_pkg::*;

    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [DATA_W-1:0] read_rs;
    logic [DATA_W-1:0] read_rt;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (
        output rs, rt, out_valid, out_addr, out_data,
        input  read_rs, read_rt, out_ready
    );

    modport slave (
        input  rs, rt, out_valid, out_addr, out_data,
        output read_rs, read_rt, out_ready
    );
endinterface

// File: rtl/regfile_dump_reader_pair_buf.sv
// Two-entry capture buffer: both read ports are latched on the same edge so a pair is an
// atomic snapshot; sel picks which half is presented.
module rf_dump_pair_buf
    import regfile_dump_reader_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sel,
    output logic [W-1:0] o_data
);
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_load) begin
            r_a <= i_a;
            r_b <= i_b;
        end
    end

    assign o_data = i_sel ? r_b : r_a;
endmodule

// File: rtl/regfile_dump_reader.sv
// Dump engine: walks the register file two registers per pass through RS/RT and streams
// (address, value) beats on a valid/ready port, with abort and a one-cycle Done pulse.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    regfile_dump_reader_if.master io_dump,
    output logic                  o_busy,
    output logic                  o_done
);
    dump_state_e       r_state;
    logic [PAIR_W-1:0] r_pair;
    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rt;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              r_sel;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_last;
    logic              w_load;
    logic [PAIR_W-1:0] w_pair_nxt;
    logic [DATA_W-1:0] w_buf_data;

    assign w_accept   = r_valid && io_dump.out_ready;
    assign w_last     = (r_pair == PAIR_W'(NUM_REGS/2 - 1));
    assign w_load     = (r_state == ST_READ) && !i_abort;
    assign w_pair_nxt = r_pair + PAIR_W'(1);

    rf_dump_pair_buf #(.W(DATA_W)) u_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_load),
        .i_a     (io_dump.read_rs),
        .i_b     (io_dump.read_rt),
        .i_sel   (r_sel),
        .o_data  (w_buf_data)
    );

    // Abort outranks every transition, including Start and an accept on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_pair  <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_sel   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_abort) begin
            r_state <= ST_IDLE;
            r_pair  <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_sel   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_READ;
                        r_pair  <= '0;
                        r_rs    <= pair_addr('0, 1'b0);
                        r_rt    <= pair_addr('0, 1'b1);
                        r_busy  <= 1'b1;
                    end
                end
                ST_READ: begin
                    r_state <= ST_SEND_A;
                    r_valid <= 1'b1;
                    r_addr  <= pair_addr(r_pair, 1'b0);
                    r_sel   <= 1'b0;
                end
                ST_SEND_A: begin
                    if (w_accept) begin
                        r_state <= ST_SEND_B;
                        r_addr  <= pair_addr(r_pair, 1'b1);
                        r_sel   <= 1'b1;
                    end
                end
                ST_SEND_B: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        r_sel   <= 1'b0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                            r_pair  <= w_pair_nxt;
                            r_rs    <= pair_addr(w_pair_nxt, 1'b0);
                            r_rt    <= pair_addr(w_pair_nxt, 1'b1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_pair  <= '0;
                    r_rs    <= '0;
                    r_rt    <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Address/data read as zero whenever no beat is being offered.
    assign io_dump.rs        = r_rs;
    assign io_dump.rt        = r_rt;
    assign io_dump.out_valid = r_valid;
    assign io_dump.out_addr  = r_valid ? r_addr : '0;
    assign io_dump.out_data  = r_valid ? w_buf_data : '0;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: behavioural register file on the RS/RT ports, a beat
// monitor, a per-cycle table for the basic dump and directed/random dump scenarios.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } beat_t;

    typedef struct {
        logic        start;
        logic        ready;
        logic        exp_valid;
        logic [2:0]  exp_addr;
        logic [15:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
        logic        chk_rs;
        logic [2:0]  exp_rs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done;
    logic        rf_we = 1'b0;
    logic [2:0]  rf_waddr = '0;
    logic [15:0] rf_wdata = '0;
    logic [15:0] regs [NUM_REGS];
    logic [2:0]  w_rd_a, w_rd_b;

    regfile_dump_reader_if bus ();

    regfile_dump_reader dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_abort (abort),
        .io_dump (bus.master),
        .o_busy  (busy),
        .o_done  (done)
    );

    always #5 clk = ~clk;

    // Register file with the datapath/dump read-address mux (datapath idles at address 0).
    always @(posedge clk) if (rf_we) regs[rf_waddr] <= rf_wdata;
    assign w_rd_a      = busy ? bus.rs : 3'd0;
    assign w_rd_b      = busy ? bus.rt : 3'd0;
    assign bus.read_rs = regs[w_rd_a];
    assign bus.read_rt = regs[w_rd_b];

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    beat_t beats [$];
    logic [15:0] model [NUM_REGS];
    logic [15:0] exp_d [NUM_REGS];
    vec_t  tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: log the beat/stall offered before the edge, then sample #1 after it.
    task automatic tick();
        logic stall;
        logic [2:0] pa;
        logic [15:0] pd;
        stall = bus.out_valid && !bus.out_ready && !abort && rst_n;
        pa = bus.out_addr;
        pd = bus.out_data;
        if (bus.out_valid && bus.out_ready && !abort)
            beats.push_back('{a: bus.out_addr, d: bus.out_data});
        @(posedge clk);
        #1;
        cyc++;
        if (stall) begin
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_addr", {29'd0, bus.out_addr}, {29'd0, pa});
            chk("stall_data", {16'd0, bus.out_data}, {16'd0, pd});
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic preload(input logic [15:0] v [NUM_REGS]);
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_we = 1'b1; rf_waddr = 3'(i); rf_wdata = v[i];
            model[i] = v[i];
            tick();
        end
        rf_we = 1'b0;
    endtask

    task automatic chk_beats(input string nm, input logic [15:0] e [NUM_REGS]);
        chk({nm, "_count"}, beats.size(), NUM_REGS);
        for (int i = 0; i < NUM_REGS && i < beats.size(); i++) begin
            chk({nm, "_addr"}, {29'd0, beats[i].a}, i);
            chk({nm, "_data"}, {16'd0, beats[i].d}, {16'd0, e[i]});
        end
    endtask

    function automatic logic pick_ready(input int mode);
        case (mode)
            0: return 1'b1;
            1: return cyc[0];
            default: return ($urandom_range(0, 2) != 0);
        endcase
    endfunction

    // Start a dump and run it to Done; optional single write at edge wr_edge after Start.
    task automatic run_dump(input int mode, input bit noise, input int wr_edge,
                            input logic [2:0] wa, input logic [15:0] wd);
        int s0;
        beats.delete();
        done_cnt = 0;
        start = 1'b1;
        bus.out_ready = pick_ready(mode);
        tick();
        start = 1'b0;
        s0 = cyc;
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            bus.out_ready = pick_ready(mode);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            rf_we = (i + 1 == wr_edge);
            rf_waddr = wa;
            rf_wdata = wd;
            tick();
        end
        rf_we = 1'b0;
        start = 1'b0;
        if (done_cnt == 0) chk("dump_timeout", 32'd0, 32'd1);
        done_cyc = done_cyc - s0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("dump_done_once", done_cnt, 1);
        chk("dump_idle_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] v [NUM_REGS];
        int s0;
        int guard;

        bus.out_ready = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) v[i] = 16'h0010 + 16'(i);

        // Per-cycle expectations for a dump with OutReady held 1: row k is the state after edge k.
        for (int k = 0; k < 14; k++) begin
            tbl[k] = '{start: (k == 0), ready: 1'b1, exp_valid: 1'b0, exp_addr: 3'd0,
                       exp_data: 16'd0, exp_busy: (k != 13), exp_done: (k == 12),
                       chk_rs: 1'b0, exp_rs: 3'd0};
            if (k < 12 && k % 3 == 0) begin
                tbl[k].chk_rs = 1'b1;
                tbl[k].exp_rs = 3'(2 * (k / 3));
            end
            if (k > 0 && k < 12 && k % 3 != 0) begin
                tbl[k].exp_valid = 1'b1;
                tbl[k].exp_addr  = 3'(2 * ((k - 1) / 3) + (k - 1) % 3);
                tbl[k].exp_data  = 16'h0010 + 16'(tbl[k].exp_addr);
            end
        end

        // Reset state
        #12;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_addr", {29'd0, bus.out_addr}, 32'd0);
        chk("rst_data", {16'd0, bus.out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rs", {26'd0, bus.rs, bus.rt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven basic dump
        preload(v);
        beats.delete();
        done_cnt = 0;
        s0 = cyc;
        for (int k = 0; k < 14; k++) begin
            start = tbl[k].start;
            bus.out_ready = tbl[k].ready;
            tick();
            chk("tbl_valid", {31'd0, bus.out_valid}, {31'd0, tbl[k].exp_valid});
            chk("tbl_addr", {29'd0, bus.out_addr}, {29'd0, tbl[k].exp_addr});
            chk("tbl_data", {16'd0, bus.out_data}, {16'd0, tbl[k].exp_data});
            chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[k].exp_busy});
            chk("tbl_done", {31'd0, done}, {31'd0, tbl[k].exp_done});
            if (tbl[k].chk_rs) begin
                chk("tbl_rs", {29'd0, bus.rs}, {29'd0, tbl[k].exp_rs});
                chk("tbl_rt", {29'd0, bus.rt}, {29'd0, tbl[k].exp_rs + 3'd1});
            end
        end
        start = 1'b0;
        chk_beats("basic", v);
        chk("basic_done_latency", done_cyc - s0 - 1, 12);

        // OutReady toggling: same beats, data stable while stalled
        run_dump(1, 1'b0, -1, 3'd0, 16'd0);
        chk_beats("toggle", v);

        // Write to a not-yet-captured pair is seen
        run_dump(0, 1'b0, 1, 3'd5, 16'hBEEF);
        exp_d = v; exp_d[5] = 16'hBEEF;
        chk_beats("late_write", exp_d);
        model[5] = 16'hBEEF;

        // Write to an already-captured pair is not seen
        v = model;
        run_dump(0, 1'b0, 2, 3'd1, 16'h1234);
        chk_beats("early_write", v);
        model[1] = 16'h1234;
        v = model;

        // Abort during SEND_B of pair 1, accept offered on the same edge
        beats.delete();
        done_cnt = 0;
        start = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(bus.out_valid && bus.out_addr == 3'd3) && guard < 50) begin
            tick();
            guard++;
        end
        chk("abort_reach_sendb", {31'd0, bus.out_valid}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick(); tick(); tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_partial_beats", beats.size(), 3);

        // Start together with Abort in IDLE is ignored
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {31'd0, busy}, 32'd0);

        run_dump(0, 1'b0, -1, 3'd0, 16'd0);
        chk_beats("after_abort", v);

        // Asynchronous reset mid-dump
        start = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_addr_data", {13'd0, bus.out_addr, bus.out_data}, 32'd0);
        chk("arst_busy_done", {30'd0, busy, done}, 32'd0);
        chk("arst_rs", {26'd0, bus.rs, bus.rt}, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("arst_idle", {31'd0, busy}, 32'd0);

        // Start pulses while busy are ignored
        run_dump(2, 1'b1, -1, 3'd0, 16'd0);
        chk_beats("start_noise", v);

        // Randomized contents and back-pressure against the array model
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NUM_REGS; i++) v[i] = 16'($urandom);
            preload(v);
            run_dump(2, 1'b1, -1, 3'd0, 16'd0);
            chk_beats("random", model);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
